// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and sequencer FSM state encoding
package alu_pkg;

   localparam logic [2:0] OP_0 = 3'd0;
   localparam logic [2:0] OP_1 = 3'd1;
   localparam logic [2:0] OP_2 = 3'd2;
   localparam logic [2:0] OP_3 = 3'd3;
   localparam logic [2:0] OP_4 = 3'd4;
   localparam logic [2:0] OP_5 = 3'd5;
   localparam logic [2:0] OP_6 = 3'd6;
   localparam logic [2:0] OP_7 = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_EXEC = 2'b10,
      S_SHOW = 2'b11
   } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - board/ALU side signals of the op sequencer
interface alu_op_sequencer_if;

   logic [7:0]  ins;
   logic        btn_start;
   logic        btn_next;
   logic        btn_stop;
   logic        auto_en;
   logic [31:0] alu_res;
   logic [7:0]  alu_num1;
   logic [2:0]  alu_op;
   logic [31:0] res_q;
   logic        res_valid;
   logic        busy;
   logic        done;

   modport master (
      output ins, btn_start, btn_next, btn_stop, auto_en, alu_res,
      input  alu_num1, alu_op, res_q, res_valid, busy, done
   );

   modport slave (
      input  ins, btn_start, btn_next, btn_stop, auto_en, alu_res,
      output alu_num1, alu_op, res_q, res_valid, busy, done
   );

endinterface

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop synchroniser plus registered rising-edge pulse
module btn_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_pulse;

   // a held button produces one pulse because r_prev tracks the synced level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_pulse <= r_sync2 & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - steps the ALU through all eight ops for one latched operand
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 2,
   parameter int unsigned DWELL       = 100000000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic             clk,
   input  logic             reset,
   alu_op_sequencer_if.slave io_seq
);

   localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic w_start_pls;
   logic w_next_pls;
   logic w_stop_pls;
   logic w_advance;

   state_t           r_state,     w_state_nxt;
   logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
   logic [7:0]       r_alu_num1,  w_alu_num1_nxt;
   logic [2:0]       r_alu_op,    w_alu_op_nxt;
   logic [31:0]      r_res_q,     w_res_q_nxt;
   logic             r_res_valid, w_res_valid_nxt;
   logic             r_done,      w_done_nxt;

   btn_edge_sync u_start (.clk(clk), .reset(reset), .i_btn(io_seq.btn_start), .o_pulse(w_start_pls));
   btn_edge_sync u_next  (.clk(clk), .reset(reset), .i_btn(io_seq.btn_next),  .o_pulse(w_next_pls));
   btn_edge_sync u_stop  (.clk(clk), .reset(reset), .i_btn(io_seq.btn_stop),  .o_pulse(w_stop_pls));

   // auto_en is looked at every cycle so a mode flip mid-dwell acts at once
   assign w_advance = io_seq.auto_en ? (r_cnt == DWELL_LAST) : w_next_pls;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_alu_num1  <= '0;
         r_alu_op    <= OP_0;
         r_res_q     <= '0;
         r_res_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_alu_num1  <= w_alu_num1_nxt;
         r_alu_op    <= w_alu_op_nxt;
         r_res_q     <= w_res_q_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_done      <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_alu_num1_nxt  = r_alu_num1;
      w_alu_op_nxt    = r_alu_op;
      w_res_q_nxt     = r_res_q;
      w_res_valid_nxt = 1'b0;
      w_done_nxt      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_start_pls) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_stop_pls) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_alu_num1_nxt = io_seq.ins;
               w_alu_op_nxt   = OP_0;
               w_cnt_nxt      = '0;
               w_state_nxt    = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_stop_pls) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == EXEC_LAST) begin
               w_res_q_nxt     = io_seq.alu_res;
               w_res_valid_nxt = 1'b1;
               w_cnt_nxt       = '0;
               w_state_nxt     = S_SHOW;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         S_SHOW: begin
            // stop outranks both dwell expiry and a manual step
            if (w_stop_pls) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_advance) begin
               w_cnt_nxt = '0;
               if (r_alu_op == OP_7) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_alu_op_nxt = r_alu_op + 3'd1;
                  w_state_nxt  = S_EXEC;
               end
            end else if (io_seq.auto_en) begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
               w_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign io_seq.alu_num1  = r_alu_num1;
   assign io_seq.alu_op    = r_alu_op;
   assign io_seq.res_q     = r_res_q;
   assign io_seq.res_valid = r_res_valid;
   assign io_seq.done      = r_done;
   assign io_seq.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed checks of alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   int   rv_cnt = 0;
   int   done_cnt = 0;

   alu_op_sequencer_if bus ();

   alu_op_sequencer #(
      .EXEC_CYCLES(2),
      .DWELL      (4),
      .CNT_W      (27)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io_seq(bus)
   );

   always #5 clk = ~clk;

   // stand-in ALU: distinct, operand-dependent result per op code
   function automatic logic [31:0] alu_f(input logic [7:0] n, input logic [2:0] op);
      logic [7:0] s;
      s = n + {5'b0, op};
      return {op, 5'b0, s, ~n, n};
   endfunction

   assign bus.alu_res = alu_f(bus.alu_num1, bus.alu_op);

   always @(negedge clk) begin
      if (bus.res_valid) rv_cnt++;
      if (bus.done) done_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // 0=start 1=next 2=stop: hold 4 cycles, release, then let the FSM settle
   task automatic press(input int which, input int settle);
      case (which)
         0: bus.btn_start = 1'b1;
         1: bus.btn_next  = 1'b1;
         default: bus.btn_stop = 1'b1;
      endcase
      ticks(4);
      bus.btn_start = 1'b0;
      bus.btn_next  = 1'b0;
      bus.btn_stop  = 1'b0;
      ticks(settle);
   endtask

   task automatic wait_rv(input int limit, output int cyc);
      cyc = 0;
      while (!bus.res_valid && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int base;

      bus.ins       = 8'($urandom);
      bus.auto_en   = 1'($urandom);
      bus.btn_start = 1'($urandom);
      bus.btn_next  = 1'($urandom);
      bus.btn_stop  = 1'($urandom);
      ticks(3);
      chk("rst_num1",  {24'b0, bus.alu_num1}, 32'h0);
      chk("rst_op",    {29'b0, bus.alu_op}, 32'h0);
      chk("rst_res_q", bus.res_q, 32'h0);
      chk("rst_flags", {29'b0, bus.res_valid, bus.busy, bus.done}, 32'h0);

      bus.btn_start = 1'b0;
      bus.btn_next  = 1'b0;
      bus.btn_stop  = 1'b0;
      reset = 1'b1;
      ticks(6);
      chk("idle_busy", {31'b0, bus.busy}, 32'h0);
      chk("idle_rv_cnt", rv_cnt, 0);

      // auto run, start button held for the whole run
      bus.ins = 8'h5A;
      bus.auto_en = 1'b1;
      bus.btn_start = 1'b1;
      cyc = 0;
      while (!bus.busy && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("auto_busy_rise", {31'b0, bus.busy}, 32'h1);
      wait_rv(20, cyc);
      chk("auto_first_lat", cyc, 3);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            tick();
            wait_rv(20, cyc);
            chk($sformatf("auto_spacing_%0d", k), cyc + 1, 6);
         end
         chk($sformatf("auto_rv_%0d", k), {31'b0, bus.res_valid}, 32'h1);
         chk($sformatf("auto_op_%0d", k), {29'b0, bus.alu_op}, k);
         chk($sformatf("auto_res_%0d", k), bus.res_q, alu_f(8'h5A, 3'(k)));
      end
      chk("auto_num1", {24'b0, bus.alu_num1}, 32'h5A);
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("auto_done_lat", cyc, 4);
      chk("auto_done_busy", {31'b0, bus.busy}, 32'h0);
      chk("auto_done_op", {29'b0, bus.alu_op}, 32'h7);
      ticks(12);
      bus.btn_start = 1'b0;
      ticks(8);
      chk("auto_done_once", done_cnt, 1);
      chk("auto_rv_total", rv_cnt, 8);
      chk("auto_idle_after", {31'b0, bus.busy}, 32'h0);

      // manual stepping
      bus.auto_en = 1'b0;
      bus.ins = 8'h3C;
      base = rv_cnt;
      press(0, 15);
      for (int k = 0; k < 3; k++) press(1, 10);
      chk("man_op3", {29'b0, bus.alu_op}, 32'h3);
      chk("man_rv4", rv_cnt - base, 4);
      chk("man_res3", bus.res_q, alu_f(8'h3C, 3'd3));
      bus.btn_next = 1'b1;
      ticks(20);
      bus.btn_next = 1'b0;
      ticks(10);
      chk("man_hold_op4", {29'b0, bus.alu_op}, 32'h4);
      chk("man_hold_rv5", rv_cnt - base, 5);

      // abort during EXEC of op 5: stop trails next by one cycle
      bus.btn_next = 1'b1;
      tick();
      bus.btn_stop = 1'b1;
      cyc = 0;
      while (bus.alu_op != 3'd5 && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("abort_in_exec", {30'b0, bus.busy, bus.res_valid}, 32'h2);
      tick();
      chk("abort_idle_next", {31'b0, bus.busy}, 32'h0);
      bus.btn_next = 1'b0;
      bus.btn_stop = 1'b0;
      ticks(10);
      chk("abort_op5", {29'b0, bus.alu_op}, 32'h5);
      chk("abort_res_op4", bus.res_q, alu_f(8'h3C, 3'd4));
      chk("abort_no_rv", rv_cnt - base, 5);

      // stop and next together in SHOW
      bus.ins = 8'hC3;
      press(0, 15);
      press(1, 10);
      chk("sim_pre_op1", {29'b0, bus.alu_op}, 32'h1);
      bus.btn_next = 1'b1;
      bus.btn_stop = 1'b1;
      ticks(4);
      bus.btn_next = 1'b0;
      bus.btn_stop = 1'b0;
      ticks(10);
      chk("sim_idle", {31'b0, bus.busy}, 32'h0);
      chk("sim_op1", {29'b0, bus.alu_op}, 32'h1);
      chk("sim_res", bus.res_q, alu_f(8'hC3, 3'd1));

      // start while busy is ignored
      bus.ins = 8'h11;
      base = rv_cnt;
      press(0, 15);
      bus.ins = 8'h22;
      press(0, 15);
      chk("busy_start_num1", {24'b0, bus.alu_num1}, 32'h11);
      chk("busy_start_op", {29'b0, bus.alu_op}, 32'h0);
      chk("busy_start_rv", rv_cnt - base, 1);

      // async reset in SHOW of op 3
      for (int k = 0; k < 3; k++) press(1, 10);
      chk("mid_pre_op3", {29'b0, bus.alu_op}, 32'h3);
      reset = 1'b0;
      #1;
      chk("mid_rst_num1", {24'b0, bus.alu_num1}, 32'h0);
      chk("mid_rst_op", {29'b0, bus.alu_op}, 32'h0);
      chk("mid_rst_res", bus.res_q, 32'h0);
      chk("mid_rst_flags", {29'b0, bus.res_valid, bus.busy, bus.done}, 32'h0);
      tick();
      reset = 1'b1;
      ticks(5);
      chk("mid_post_idle", {31'b0, bus.busy}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
